// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: FILL, WASH, RINSE xN, DRAIN, SPIN, OVER with pause/door hold and abort.
// Optional prewash phase (code 7) enabled by defining WASH_PREWASH_EN.
module wash_cycle_ctrl #(
    parameter int CNT_W      = 12,
    parameter int FILL_T     = 120,
    parameter int WASH_T     = 1200,
    parameter int RINSE_T    = 600,
    parameter int RINSE_REPS = 2,
    parameter int DRAIN_T    = 180,
    parameter int SPIN_T     = 300,
    parameter int OVER_T     = 30
`ifdef WASH_PREWASH_EN
    ,
    parameter int PREWASH_T  = 300
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef WASH_PREWASH_EN
    input  logic             prewash,
`endif
    input  logic             pause,
    input  logic             door_open,
    input  logic             abort,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] phase_timer,
    output logic [3:0]       rinse_num,
    output logic             held,
    output logic             aborted,
    output logic             done,
    output logic             busy,
    output logic             door_lock,
    output logic             valve,
    output logic             motor,
    output logic             motor_fast,
    output logic             pump
);

    localparam longint TMAX = longint'(1) << CNT_W;

    function automatic bit t_ok(input int t);
        return (t >= 1) && (longint'(t) < TMAX);
    endfunction

`ifdef WASH_PREWASH_EN
    localparam bit PRE_OK = t_ok(PREWASH_T);
`else
    localparam bit PRE_OK = 1'b1;
`endif
    localparam bit PARAMS_OK = t_ok(FILL_T) && t_ok(WASH_T) && t_ok(RINSE_T) && t_ok(DRAIN_T)
                            && t_ok(SPIN_T) && t_ok(OVER_T) && PRE_OK
                            && (RINSE_REPS >= 1) && (RINSE_REPS <= 15);

    if (!PARAMS_OK) begin : g_param_check
        $error("wash_cycle_ctrl: phase durations must be in 1..2^CNT_W-1 and RINSE_REPS in 1..15");
    end

    localparam logic [CNT_W-1:0] FILL_L  = CNT_W'(FILL_T);
    localparam logic [CNT_W-1:0] WASH_L  = CNT_W'(WASH_T);
    localparam logic [CNT_W-1:0] RINSE_L = CNT_W'(RINSE_T);
    localparam logic [CNT_W-1:0] DRAIN_L = CNT_W'(DRAIN_T);
    localparam logic [CNT_W-1:0] SPIN_L  = CNT_W'(SPIN_T);
    localparam logic [CNT_W-1:0] OVER_L  = CNT_W'(OVER_T);
    localparam logic [3:0]       REPS_L  = 4'(RINSE_REPS);
`ifdef WASH_PREWASH_EN
    localparam logic [CNT_W-1:0] PRE_L   = CNT_W'(PREWASH_T);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_WASH    = 3'd2,
        S_RINSE   = 3'd3,
        S_DRAIN   = 3'd4,
        S_SPIN    = 3'd5,
        S_OVER    = 3'd6
`ifdef WASH_PREWASH_EN
        ,
        S_PREWASH = 3'd7
`endif
    } state_t;

    state_t state;
    logic   hold_req;
    logic   motor_ph;
`ifdef WASH_PREWASH_EN
    logic   prewash_sel;
`endif

    assign hold_req = pause | door_open;

    // held tracks the hold request only in busy phases, so it is forced low on entry to IDLE/OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            phase_timer <= '0;
            rinse_num   <= '0;
            held        <= 1'b0;
            aborted     <= 1'b0;
`ifdef WASH_PREWASH_EN
            prewash_sel <= 1'b0;
`endif
        end else if (abort && busy) begin
            state       <= S_DRAIN;
            phase_timer <= DRAIN_L;
            rinse_num   <= '0;
            aborted     <= 1'b1;
            held        <= hold_req;
        end else if (held) begin
            held <= hold_req;
        end else begin
            held <= hold_req && busy;
            if (state == S_IDLE) begin
                if (start && !door_open) begin
                    state       <= S_FILL;
                    phase_timer <= FILL_L;
                    aborted     <= 1'b0;
                    held        <= hold_req;
`ifdef WASH_PREWASH_EN
                    prewash_sel <= prewash;
`endif
                end
            end else if (phase_timer == CNT_W'(1)) begin
                case (state)
                    S_FILL: begin
`ifdef WASH_PREWASH_EN
                        state       <= prewash_sel ? S_PREWASH : S_WASH;
                        phase_timer <= prewash_sel ? PRE_L : WASH_L;
`else
                        state       <= S_WASH;
                        phase_timer <= WASH_L;
`endif
                    end
`ifdef WASH_PREWASH_EN
                    S_PREWASH: begin
                        state       <= S_WASH;
                        phase_timer <= WASH_L;
                    end
`endif
                    S_WASH: begin
                        state       <= S_RINSE;
                        phase_timer <= RINSE_L;
                        rinse_num   <= 4'd1;
                    end
                    S_RINSE: begin
                        if (rinse_num < REPS_L) begin
                            phase_timer <= RINSE_L;
                            rinse_num   <= rinse_num + 4'd1;
                        end else begin
                            state       <= S_DRAIN;
                            phase_timer <= DRAIN_L;
                            rinse_num   <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (aborted) begin
                            state       <= S_IDLE;
                            phase_timer <= '0;
                            held        <= 1'b0;
                        end else begin
                            state       <= S_SPIN;
                            phase_timer <= SPIN_L;
                        end
                    end
                    S_SPIN: begin
                        state       <= S_OVER;
                        phase_timer <= OVER_L;
                        held        <= 1'b0;
                    end
                    default: begin
                        state       <= S_IDLE;
                        phase_timer <= '0;
                        rinse_num   <= '0;
                        held        <= 1'b0;
                    end
                endcase
            end else begin
                phase_timer <= phase_timer - CNT_W'(1);
            end
        end
    end

`ifdef WASH_PREWASH_EN
    assign motor_ph = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN) || (state == S_PREWASH);
`else
    assign motor_ph = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
`endif

    assign phase      = state;
    assign busy       = (state != S_IDLE) && (state != S_OVER);
    assign door_lock  = busy;
    assign done       = (state == S_OVER);
    assign valve      = (state == S_FILL) && !held;
    assign motor      = motor_ph && !held;
    assign motor_fast = (state == S_SPIN) && !held;
    assign pump       = ((state == S_DRAIN) || (state == S_SPIN)) && !held;

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
Parametrised washing-machine cycle controller. It sequences FILL, WASH, RINSE (repeated), DRAIN, SPIN and OVER using a per-phase down-counting timer, with programmable durations. It adds pause, door interlock, abort and direct actuator outputs. It sits between the front-panel input logic and the valve/motor/pump drivers.

Parameters:
CNT_W, 12, phase timer width.
FILL_T, 120, FILL duration in clk cycles.
WASH_T, 1200, WASH duration.
RINSE_T, 600, duration of one rinse pass.
RINSE_REPS, 2, number of back-to-back rinse passes (1..15).
DRAIN_T, 180, DRAIN duration.
SPIN_T, 300, SPIN duration.
OVER_T, 30, cycles that done is held high.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin cycle (level, sampled in IDLE)
pause  in  1  hold timer while high
door_open  in  1  door sensor; 1 = open
abort  in  1  single-cycle abort request
phase  out  3  IDLE=0 FILL=1 WASH=2 RINSE=3 DRAIN=4 SPIN=5 OVER=6
phase_timer  out  CNT_W  remaining cycles in current phase
rinse_num  out  4  current rinse pass, 1-based; 0 outside RINSE
held  out  1  timer frozen by pause/door
aborted  out  1  sticky; set on abort, cleared on next start
done  out  1  high only in OVER
busy  out  1  phase not IDLE and not OVER
door_lock  out  1  equals busy
valve  out  1  FILL && !held
motor  out  1  (WASH|RINSE|SPIN) && !held
motor_fast  out  1  SPIN && !held
pump  out  1  (DRAIN|SPIN) && !held

Behaviour:
- Reset (clk edge with rst=1): phase=IDLE, phase_timer=0, rinse_num=0, held=0, aborted=0. All decoded outputs are therefore 0.
- Priority per cycle: rst > abort > hold > timer expiry > start.
- IDLE -> FILL when start=1 && door_open=0. Timer is loaded with FILL_T and aborted is cleared. start is ignored in every other phase.
- Phase entry loads phase_timer with that phase's T. Each unheld cycle decrements it. When phase_timer==1 and not held, the next edge enters the next phase. Each phase therefore lasts exactly T unheld cycles.
- Sequence: FILL -> WASH -> RINSE(pass 1..RINSE_REPS) -> DRAIN -> SPIN -> OVER -> IDLE.
- RINSE pass expiry with rinse_num<RINSE_REPS: stay in RINSE, increment rinse_num, reload RINSE_T. The last pass goes to DRAIN.
- OVER lasts OVER_T cycles with done=1, then returns to IDLE (timer 0).
- held = (pause | door_open) while busy. It is a registered output and is updated each edge, so the timer freezes starting on the cycle after hold is sampled. While held, phase and timer do not change and actuators are forced off.
- Release of hold resumes the countdown from the frozen value. No reload occurs.
- abort while busy: next phase=DRAIN, timer=DRAIN_T, aborted=1, rinse_num=0. DRAIN expiry after an abort goes directly to IDLE, skipping SPIN and OVER, so done is never asserted. abort during DRAIN restarts DRAIN_T. abort in IDLE/OVER is ignored.
- door_open in IDLE blocks start. door_open in OVER has no effect.
- rst mid-cycle returns to IDLE within one edge regardless of phase or hold.
- Elaboration check: every *_T must be >=1 and <2^CNT_W, and RINSE_REPS must be in 1..15. Violations are flagged as errors.

Optional Feature:
Macro WASH_PREWASH_EN.
- Defined: adds parameter PREWASH_T (default 300), input prewash (1 bit) and phase code PREWASH=7.
- prewash is sampled with start. If it was 1, FILL -> PREWASH (motor=1) -> WASH.
- Undefined: no prewash port and code 7 never occurs. FILL goes directly to WASH.

Test Plan:
Params FILL_T=4, WASH_T=6, RINSE_T=3, RINSE_REPS=2, DRAIN_T=2, SPIN_T=5, OVER_T=2.
- Nominal run, start pulse: FILL 4, WASH 6, RINSE 6 (rinse_num 1 then 2), DRAIN 2, SPIN 5 cycles, then done=1 for 2 cycles, then IDLE. 25 cycles from FILL entry to IDLE.
- pause=1 for 3 cycles at WASH timer=4: held=1, motor=0, timer holds at 4 (or 3 if the decrement lands on the same edge, checked per the registered held). WASH occupancy totals 6 unheld cycles.
- door_open=1 with start=1 in IDLE: phase stays 0. Lower door_open with start still high: FILL next edge, door_lock=1.
- abort in RINSE pass 1: DRAIN for 2 cycles, then IDLE. aborted=1, done never 1. Next start clears aborted.
- rst asserted in SPIN timer=3: next edge phase=0, all outputs 0. start then runs a clean full cycle.
- WASH_PREWASH_EN defined, PREWASH_T=3, prewash=1: FILL -> phase 7 for 3 cycles with motor=1 -> WASH.
